// File: rtl/dmem_req_arbiter.sv
// dmem_req_arbiter
// Shares the MMU data-memory port between the two issue lanes of the
// dual-issue pipeline. Grants one request per cycle (lane 0 first), keeps an
// in-order owner FIFO of in-flight transactions, and routes each response
// back to the lane that issued it. A pipeline flush marks every in-flight
// entry as cancelled so that its response is dropped when it arrives.
module dmem_req_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,

    input  logic [1:0]       lane_req,
    input  logic [1:0]       lane_wr,
    input  logic [1:0][1:0]  lane_size,
    input  logic [1:0][31:0] lane_addr,
    input  logic [1:0][31:0] lane_wdata,
    output logic [1:0]       lane_addr_ok,
    output logic [1:0]       lane_data_ok,
    output logic [31:0]      lane_rdata,

    output logic             mmu_req,
    output logic             mmu_wr,
    output logic [1:0]       mmu_size,
    output logic [31:0]      mmu_addr,
    output logic [3:0]       mmu_wstrb,
    output logic [31:0]      mmu_wdata,
    input  logic             mmu_addr_ok,
    input  logic             mmu_data_ok,
    input  logic [31:0]      mmu_rdata
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

    // Owner FIFO: one lane id and one cancel flag per in-flight transaction.
    logic [MAX_OUTSTANDING-1:0] owner_lane;
    logic [MAX_OUTSTANDING-1:0] owner_cancel;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    logic        fifo_full;
    logic        fifo_empty;
    logic        grant;
    logic        accept;
    logic        pop;
    logic        head_lane;
    logic        head_cancel;
    logic        deliver;

    logic        g_wr;
    logic [1:0]  g_size;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_strb;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // Fixed priority: the older lane wins whenever it is requesting.
    assign grant = ~lane_req[0];

    assign g_wr    = lane_wr[grant];
    assign g_size  = lane_size[grant];
    assign g_addr  = lane_addr[grant];
    assign g_wdata = lane_wdata[grant];

    // Store data is replicated into every byte lane; the strobe picks the
    // bytes actually written. Size 3 falls through to the word case.
    always_comb begin
        fmt_wdata = g_wdata;
        fmt_strb  = 4'hF;
        case (g_size)
            2'd0: begin
                fmt_wdata = {4{g_wdata[7:0]}};
                fmt_strb  = 4'b0001 << g_addr[1:0];
            end
            2'd1: begin
                fmt_wdata = {2{g_wdata[15:0]}};
                fmt_strb  = g_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt_wdata = g_wdata;
                fmt_strb  = 4'hF;
            end
        endcase
    end

    // Full blocks new requests even when a pop lands in the same cycle.
    assign mmu_req   = (|lane_req) && !fifo_full && !flush && !reset;
    assign mmu_wr    = mmu_req && g_wr;
    assign mmu_size  = g_size;
    assign mmu_addr  = g_addr;
    assign mmu_wstrb = mmu_wr ? fmt_strb : 4'b0000;
    assign mmu_wdata = fmt_wdata;

    assign accept       = mmu_req && mmu_addr_ok;
    assign lane_addr_ok = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    // A stray response with nothing outstanding is ignored.
    assign pop         = mmu_data_ok && !fifo_empty && !reset;
    assign head_lane   = owner_lane[rd_ptr];
    assign head_cancel = owner_cancel[rd_ptr];

    // A flush in the same cycle cancels the head being popped as well.
    assign deliver      = pop && !head_cancel && !flush;
    assign lane_data_ok = deliver ? (head_lane ? 2'b10 : 2'b01) : 2'b00;
    assign lane_rdata   = mmu_rdata;

    // Owner FIFO update: push on accept, pop on response, cancel-all on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_lane   <= '0;
            owner_cancel <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            // Pointers are left alone on flush; cancelled entries drain as
            // their responses come back. Accept never coincides with flush.
            if (flush) begin
                owner_cancel <= '1;
            end
            if (accept) begin
                owner_lane[wr_ptr]   <= grant;
                owner_cancel[wr_ptr] <= 1'b0;
                wr_ptr               <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The MMU must only answer transactions that were accepted.
    a_no_stray_response: assert property (
        @(posedge clk) disable iff (reset) !(mmu_data_ok && fifo_empty)
    );

endmodule

// File: doc/dmem_req_arbiter.md
Name: dmem_req_arbiter

Overview:
- Shares the single MMU data-memory port between the two issue lanes (lane 0 older, lane 1 younger) of the dual-issue pipeline.
- Accepts per-lane load/store requests from the EX stage and drives one request per cycle to the MMU.
- Records which lane owns each in-flight transaction and routes every `mmu_data_ok`/`mmu_rdata` back to that lane in order.
- On pipeline flush, discards responses belonging to cancelled transactions.

Parameters:
- MAX_OUTSTANDING, 2: depth of the in-order owner FIFO; the maximum number of accepted-but-unanswered transactions (power of two, ≥ 2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; cancels all in-flight transactions
- lane_req  in  2  per-lane request valid (bit 0 = lane 0)
- lane_wr  in  2  per-lane store (1) / load (0)
- lane_size  in  2x2  per-lane access size: 0 = byte, 1 = half, 2 = word
- lane_addr  in  2x32  per-lane byte address
- lane_wdata  in  2x32  per-lane store data, unaligned (value in the low bits)
- lane_addr_ok  out  2  per-lane request accepted this cycle
- lane_data_ok  out  2  per-lane response valid this cycle
- lane_rdata  out  32  response data, shared; valid where the matching lane_data_ok bit is 1
- mmu_req  out  1  request valid to the MMU
- mmu_wr  out  1  store / load
- mmu_size  out  2  access size
- mmu_addr  out  32  byte address
- mmu_wstrb  out  4  byte write strobe (all zero for loads)
- mmu_wdata  out  32  store data replicated into byte lanes
- mmu_addr_ok  in  1  MMU accepts the request
- mmu_data_ok  in  1  MMU returns a response (in order)
- mmu_rdata  in  32  MMU read data

Behaviour:
- Reset: owner FIFO empty; all cancel bits 0. `mmu_req`, `lane_addr_ok`, `lane_data_ok` are 0. `mmu_wr`, `mmu_wstrb` are 0.
- Full condition: count == MAX_OUTSTANDING.
- Grant is fixed priority: lane 0 if `lane_req[0]`, else lane 1.
- `mmu_req = |lane_req && !full && !flush`. All mmu_* request fields are muxed combinationally from the granted lane.
- Handshake: a transaction is accepted when `mmu_req && mmu_addr_ok`.
  - `lane_addr_ok[g]` = 1 that cycle, where g is the granted lane; the other bit stays 0.
  - An entry {lane = g, cancel = 0} is pushed to the owner FIFO.
  - At most one accept per cycle. A lane not accepted holds its request; there is zero-cycle request latency.
- Full blocks new requests even if a pop happens in the same cycle.
- Store formatting:
  - byte: wdata = {4{b}}, wstrb = 1 << addr[1:0]
  - half: wdata = {2{h}}, wstrb = addr[1] ? 4'b1100 : 4'b0011
  - word: wdata unchanged, wstrb = 4'hF
  - Loads: wstrb = 0. Size 3 is treated as word.
- Response: `mmu_data_ok` pops the FIFO head in the same cycle.
  - If the head cancel bit is 0 and flush is 0: `lane_data_ok[head.lane]` = 1 and `lane_rdata = mmu_rdata`, combinationally.
  - Otherwise the response is dropped and `lane_data_ok` = 0.
  - `lane_rdata` is raw `mmu_rdata`; sign/zero extension is done downstream.
- Flush:
  - Sets the cancel bit of every FIFO entry, including the head being popped that cycle.
  - Blocks `mmu_req` that cycle.
  - Does not reset pointers: cancelled entries drain as their responses arrive.
  - A new request may issue the cycle after flush while cancelled entries are still draining.
- Push and pop in the same cycle: count unchanged, pointers both advance modulo MAX_OUTSTANDING.
- A push that coincides with flush cannot occur, because `mmu_req` is 0 during flush.
- `mmu_data_ok` while the FIFO is empty: ignored, with no state change (simulation assertion).
- Reset mid-transaction: FIFO is cleared. The MMU is reset in the same cycle, so no stale responses arrive.

Test Plan:
- **Single load.** lane 0 load, addr 0x100, word; `mmu_addr_ok` = 1 at cycle 0, `mmu_data_ok` with rdata 0xDEADBEEF at cycle 2 -> `lane_addr_ok` = 01 at cycle 0; `lane_data_ok` = 01 and `lane_rdata` = 0xDEADBEEF at cycle 2.
- **Both lanes request together.** Lane 0 is granted first and lane 1 in the next cycle. Responses R0 = 0x11, R1 = 0x22 return in order -> `lane_data_ok` = 01 with 0x11, then 10 with 0x22.
- **Store formatting.** byte store, addr 0x203, wdata 0xAB -> wstrb = 1000, wdata = 0xABABABAB. half store, addr 0x202, wdata 0x1234 -> wstrb = 1100, wdata = 0x12341234.
- **Full stall.** Two accepted loads with no response; lane 0 still requesting -> `mmu_req` = 0. In the cycle after the first `mmu_data_ok`, `mmu_req` = 1 again.
- **Flush.** Flush with 2 in flight, then a new lane 1 load is accepted; three responses arrive -> the first two produce no `lane_data_ok`; the third gives `lane_data_ok` = 10.
- **Flush and response in the same cycle.** Flush coincides with `mmu_data_ok` -> the response is dropped and count decrements by 1.
